recorder_ctrl: RTL

RECORDER_CTRL -- requirements
Module: recorder_ctrl

---
 rtl/recorder_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/recorder_ctrl.sv
// recorder_ctrl: control FSM for a voice recorder / player.
//
// Tracks IDLE / PLAY / RECORD / PAUSE, runs a one-second prescaler while
// recording or playing, and keeps the elapsed-time / playback-position timer.
// In PLAY the position advances by 1 (normal), by the speed factor (fast,
// clamped to the recorded length), or by 1 every <speed> seconds (slow).
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_play, i_record, i_pause, i_stop   one-cycle key pulses
//   i_speed_up, i_speed_down            one-cycle speed pulses (1..8)
//   i_slow            level: 1 = slow-motion, 0 = fast
//   o_state           1 IDLE, 2 PLAY, 3 RECORD, 4 PAUSE
//   o_timer           seconds recorded / playback position
//   o_speed_stat      0 normal, 1 fast, 2 slow
//   o_speed           speed factor 1..8
//   o_rec_en, o_play_en   high while in RECORD / PLAY
//   o_clr             one-cycle pulse on entry to RECORD or PLAY
// Every output is a flop and reacts one cycle after its trigger.
module recorder_ctrl #(
  parameter int TICKS_PER_SEC = 12000000,
  parameter int MAX_SEC       = 31
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_play,
  input  logic       i_record,
  input  logic       i_pause,
  input  logic       i_stop,
  input  logic       i_speed_up,
  input  logic       i_speed_down,
  input  logic       i_slow,
  output logic [2:0] o_state,
  output logic [4:0] o_timer,
  output logic [1:0] o_speed_stat,
  output logic [3:0] o_speed,
  output logic       o_rec_en,
  output logic       o_play_en,
  output logic       o_clr
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd1,
    S_PLAY   = 3'd2,
    S_RECORD = 3'd3,
    S_PAUSE  = 3'd4
  } state_t;

  typedef enum logic [2:0] {K_NONE, K_STOP, K_PAUSE, K_RECORD, K_PLAY} key_t;

  state_t        state, state_n, target, target_n;
  logic [4:0]    timer, timer_n, rec_len, rec_len_n;
  logic [PW-1:0] presc, presc_n;
  logic [3:0]    div, div_n, speed, speed_n;
  logic [1:0]    stat_n;
  logic          clr_n;
  key_t          key;
  logic          tick;
  logic [5:0]    fast_sum;
  logic [4:0]    adv_timer;
  logic [3:0]    adv_div;
  logic [PW-1:0] presc_step;

  // Only the highest-priority key present is acted on.
  always_comb begin
    key = K_NONE;
    if (i_stop)        key = K_STOP;
    else if (i_pause)  key = K_PAUSE;
    else if (i_record) key = K_RECORD;
    else if (i_play)   key = K_PLAY;
  end

  assign tick       = (state == S_PLAY || state == S_RECORD) &&
                      (presc == PW'(TICKS_PER_SEC - 1));
  assign presc_step = tick ? '0 : presc + PW'(1);

  // Playback position advance for one cycle, by speed mode.
  always_comb begin
    adv_timer = timer;
    adv_div   = div;
    fast_sum  = {1'b0, timer} + {2'b00, speed};
    if (tick) begin
      case (o_speed_stat)
        2'd1: adv_timer = (fast_sum > {1'b0, rec_len}) ? rec_len : fast_sum[4:0];
        2'd2: begin
          if (div == speed) begin
            adv_timer = timer + 5'd1;
            adv_div   = 4'd1;
          end else begin
            adv_div   = div + 4'd1;
          end
        end
        default: adv_timer = timer + 5'd1;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    target_n  = target;
    timer_n   = timer;
    rec_len_n = rec_len;
    presc_n   = presc;
    div_n     = div;
    clr_n     = 1'b0;
    speed_n   = speed;

    case (state)
      S_IDLE: begin
        presc_n = '0;
        if (key == K_RECORD) begin
          state_n   = S_RECORD;
          timer_n   = '0;
          rec_len_n = '0;
          clr_n     = 1'b1;
        end else if (key == K_PLAY && rec_len != '0) begin
          state_n = S_PLAY;
          timer_n = '0;
          div_n   = 4'd1;
          clr_n   = 1'b1;
        end
      end
      S_RECORD: begin
        if (key == K_STOP) begin
          state_n   = S_IDLE;
          rec_len_n = timer;
          presc_n   = '0;
        end else if (key == K_PAUSE) begin
          state_n  = S_PAUSE;
          target_n = S_RECORD;
        end else if (timer == 5'(MAX_SEC)) begin
          // Timer sits at the limit for one cycle before recording ends.
          state_n   = S_IDLE;
          rec_len_n = 5'(MAX_SEC);
          presc_n   = '0;
        end else begin
          presc_n = presc_step;
          timer_n = timer + {4'b0000, tick};
        end
      end
      S_PLAY: begin
        if (key == K_STOP) begin
          state_n = S_IDLE;
          timer_n = '0;
          presc_n = '0;
        end else if (key == K_PAUSE) begin
          state_n  = S_PAUSE;
          target_n = S_PLAY;
        end else if (timer == rec_len) begin
          state_n = S_IDLE;
          timer_n = '0;
          presc_n = '0;
        end else begin
          presc_n = presc_step;
          timer_n = adv_timer;
          div_n   = adv_div;
        end
      end
      S_PAUSE: begin
        if (key == K_STOP) begin
          state_n = S_IDLE;
          presc_n = '0;
          if (target == S_RECORD) rec_len_n = timer;
          else                    timer_n   = '0;
        end else if (key == K_PAUSE || key == K_PLAY) begin
          state_n = target;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Opposing speed pulses in the same cycle cancel.
    if (i_speed_up && !i_speed_down && speed != 4'd8)
      speed_n = speed + 4'd1;
    else if (i_speed_down && !i_speed_up && speed != 4'd1)
      speed_n = speed - 4'd1;
    if (speed_n != speed) div_n = 4'd1;

    stat_n = (speed_n == 4'd1) ? 2'd0 : (i_slow ? 2'd2 : 2'd1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      target       <= S_IDLE;
      timer        <= '0;
      rec_len      <= '0;
      presc        <= '0;
      div          <= 4'd1;
      speed        <= 4'd1;
      o_speed_stat <= 2'd0;
      o_rec_en     <= 1'b0;
      o_play_en    <= 1'b0;
      o_clr        <= 1'b0;
    end else begin
      state        <= state_n;
      target       <= target_n;
      timer        <= timer_n;
      rec_len      <= rec_len_n;
      presc        <= presc_n;
      div          <= div_n;
      speed        <= speed_n;
      o_speed_stat <= stat_n;
      o_rec_en     <= (state_n == S_RECORD);
      o_play_en    <= (state_n == S_PLAY);
      o_clr        <= clr_n;
    end
  end

  assign o_state = state;
  assign o_timer = timer;
  assign o_speed = speed;

endmodule
